// File: rtl/s_axi_lite_regfile_v2.sv
// ---------------------------------------------------------------------------
// s_axi_lite_regfile_v2
//   AXI4-Lite slave register file: REG_NUM byte-strobed RW control words
//   followed by STS_NUM read-only status words in the word address map.
//   Writes to RO or unmapped words and reads of unmapped words return SLVERR.
//   Read and write channels run independent FSMs, with one transaction
//   outstanding per channel. Every READY/VALID is a flop.
//
// Build option:
//   AXIL_REGFILE_STS_RDCLR_EN  status words become sticky (|= sts_in every
//                              cycle) and are cleared by an accepted read;
//                              a bit set by sts_in on that same edge stays set.
//                              When undefined, status reads sample sts_in
//                              directly at the AR handshake.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock, async active-high reset
//   S_AXI_AW* / W* / B*         write address / data / response channels
//   S_AXI_AR* / R*              read address / data channels
//   reg_out                     flattened RW words, word k at [k*DW +: DW]
//   reg_wr_pulse                one-cycle strobe per committed RW word
//   sts_in                      flattened status inputs (S_AXI_ACLK domain)
// ---------------------------------------------------------------------------

// One RW control word: byte-strobed update plus a commit strobe.
module s_axi_lite_regfile_v2_word #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] q_o,
  output logic          pulse_o
);
  logic [DW-1:0] word_q;
  logic          pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= we_i;
      if (we_i) begin
        for (int b = 0; b < DW/8; b++) begin
          if (wstrb_i[b]) word_q[b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign q_o     = word_q;
  assign pulse_o = pulse_q;
endmodule

module s_axi_lite_regfile_v2 #(
  parameter int          REG_NUM            = 8,
  parameter int          STS_NUM            = 4,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [31:0] ERR_RDATA          = 32'hAAAA_5555
) (
  input  logic                                  S_AXI_ACLK,
  input  logic                                  S_AXI_ARESET,
  // write address
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic [2:0]                            S_AXI_AWPROT,
  input  logic                                  S_AXI_AWVALID,
  output logic                                  S_AXI_AWREADY,
  // write data
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
  input  logic                                  S_AXI_WVALID,
  output logic                                  S_AXI_WREADY,
  // write response
  output logic [1:0]                            S_AXI_BRESP,
  output logic                                  S_AXI_BVALID,
  input  logic                                  S_AXI_BREADY,
  // read address
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic [2:0]                            S_AXI_ARPROT,
  input  logic                                  S_AXI_ARVALID,
  output logic                                  S_AXI_ARREADY,
  // read data
  output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
  output logic [1:0]                            S_AXI_RRESP,
  output logic                                  S_AXI_RVALID,
  input  logic                                  S_AXI_RREADY,
  // fabric side
  output logic [REG_NUM*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [REG_NUM-1:0]                    reg_wr_pulse,
  input  logic [STS_NUM*C_S_AXI_DATA_WIDTH-1:0] sts_in
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int ADDR_LSB = $clog2(DW/8);
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [DW-1:0] ERR_WORD = DW'(ERR_RDATA);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] { W_IDLE, W_COMMIT, W_RESP } wr_state_e;
  typedef enum logic       { R_IDLE, R_RESP }           rd_state_e;

  logic clk, rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  wr_state_e           wr_state_q, wr_state_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [IDX_W-1:0]    widx_q;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     wstrb_q;
  logic                aw_hs, w_hs, wr_commit, wr_legal;
  logic [31:0]         widx32;

  assign aw_hs     = awready_q & S_AXI_AWVALID;
  assign w_hs      = wready_q  & S_AXI_WVALID;
  assign widx32    = 32'(widx_q);
  assign wr_legal  = widx32 < 32'(REG_NUM);
  assign wr_commit = (wr_state_q == W_COMMIT);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bresp_d    = bresp_q;
    bvalid_d   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) wr_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        bresp_d    = wr_legal ? RESP_OKAY : RESP_SLVERR;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        // BVALID rises one cycle after the commit edge and drops on handshake.
        bvalid_d = !(bvalid_q && S_AXI_BREADY);
        if (bvalid_q && S_AXI_BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      widx_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      if (aw_hs) widx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  // -------------------------------------------------------------------------
  // RW control words
  // -------------------------------------------------------------------------
  logic [REG_NUM-1:0][DW-1:0] reg_q;
  logic [REG_NUM-1:0]         reg_we;

  for (genvar k = 0; k < REG_NUM; k++) begin : g_word
    assign reg_we[k] = wr_commit && (widx32 == 32'(k));
    s_axi_lite_regfile_v2_word #(.DW(DW)) u_word (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (reg_we[k]),
      .wstrb_i (wstrb_q),
      .wdata_i (wdata_q),
      .q_o     (reg_q[k]),
      .pulse_o (reg_wr_pulse[k])
    );
  end

  assign reg_out = reg_q;

  // -------------------------------------------------------------------------
  // Status words
  // -------------------------------------------------------------------------
  logic [STS_NUM-1:0][DW-1:0] sts_in_w, sts_rd;
  logic                       ar_hs;
  logic [31:0]                ridx32;

  assign sts_in_w = sts_in;
  assign ridx32   = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]);

`ifdef AXIL_REGFILE_STS_RDCLR_EN
  logic [STS_NUM-1:0][DW-1:0] sts_q, sts_d;
  logic [STS_NUM-1:0]         sts_clr;

  // Clear-on-read happens on the AR handshake edge; new sts_in bits OR in
  // after the clear so a concurrent set is never lost.
  always_comb begin
    for (int j = 0; j < STS_NUM; j++) begin
      sts_clr[j] = ar_hs && (ridx32 == 32'(REG_NUM + j));
      sts_d[j]   = (sts_clr[j] ? '0 : sts_q[j]) | sts_in_w[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sts_q <= '0;
    else     sts_q <= sts_d;
  end

  assign sts_rd = sts_q;
`else
  assign sts_rd = sts_in_w;
`endif

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  rd_state_e      rd_state_q, rd_state_d;
  logic           arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]  rdata_q, rdata_d, rd_mux;
  logic [1:0]     rresp_q, rresp_d;
  logic           rd_err;

  assign ar_hs = arready_q & S_AXI_ARVALID;

  always_comb begin
    rd_mux = ERR_WORD;
    rd_err = 1'b1;
    for (int k = 0; k < REG_NUM; k++) begin
      if (ridx32 == 32'(k)) begin
        rd_mux = reg_q[k];
        rd_err = 1'b0;
      end
    end
    for (int j = 0; j < STS_NUM; j++) begin
      if (ridx32 == 32'(REG_NUM + j)) begin
        rd_mux = sts_rd[j];
        rd_err = 1'b0;
      end
    end
  end

  // Data is captured on the handshake edge (so a write committing on that
  // same edge is not seen); RVALID follows one edge later.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rvalid_d   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d    = rd_mux;
          rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        rvalid_d = !(rvalid_q && S_AXI_RREADY);
        if (rvalid_q && S_AXI_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_s_axi_lite_regfile_v2.sv
module tb_s_axi_lite_regfile_v2;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   AWADDR = '0, ARADDR = '0;
  logic [2:0]   AWPROT = '0, ARPROT = '0;
  logic         AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]   BRESP, RRESP;
  logic [31:0]  RDATA;
  logic [255:0] reg_out;
  logic [7:0]   reg_wr_pulse;
  logic [127:0] sts_in = '0;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  // Counts every committed-word strobe seen on a rising edge.
  always @(posedge clk) pulse_cnt <= pulse_cnt + $countones(reg_wr_pulse);

  s_axi_lite_regfile_v2 dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .sts_in(sts_in)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int k);
    return reg_out[k*32 +: 32];
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int  n;
    logic awh, wh;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      awh = AWVALID && AWREADY;
      wh  = WVALID && WREADY;
      step();
      if (awh) AWVALID = 1'b0;
      if (wh)  WVALID  = 1'b0;
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin step(); n++; end
    chk("wr_bvalid_seen", BVALID, 1'b1);
    resp = BRESP;
    step();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    n = 0;
    while (!ARREADY && n < 20) begin step(); n++; end
    step();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    chk("rd_rvalid_seen", RVALID, 1'b1);
    d = RDATA; resp = RRESP;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          p0, bcnt;

    // ---- reset state
    step(); step();
    chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0); chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);   chk("rst_rvalid", RVALID, 0);
    chk("rst_bresp", BRESP, 0);     chk("rst_rresp", RRESP, 0);   chk("rst_rdata", RDATA, 0);
    chk("rst_regout_lo", reg_out[63:0], 0); chk("rst_pulse", reg_wr_pulse, 0);
    rst = 1'b0;
    step();
    chk("idle_awready", AWREADY, 1); chk("idle_wready", WREADY, 1); chk("idle_arready", ARREADY, 1);

    // ---- T1: AW and W together to word1
    AWADDR = 8'h04; WDATA = 32'h1234_5678; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    p0 = pulse_cnt;
    step();                                   // handshake edge N
    AWVALID = 0; WVALID = 0;
    chk("t1_awready_busy", AWREADY, 0); chk("t1_word1_pre", word(1), 0); chk("t1_pulse_pre", reg_wr_pulse, 0);
    step();                                   // N+1: commit
    chk("t1_word1", word(1), 32'h1234_5678); chk("t1_pulse", reg_wr_pulse, 8'h02); chk("t1_bvalid_early", BVALID, 0);
    step();                                   // N+2: response
    chk("t1_pulse_off", reg_wr_pulse, 0); chk("t1_bvalid", BVALID, 1); chk("t1_bresp", BRESP, 2'b00);
    step();                                   // N+3: B handshake
    chk("t1_bvalid_done", BVALID, 0); chk("t1_awready_back", AWREADY, 1);
    chk("t1_pulse_count", pulse_cnt - p0, 1);

    // ---- T2: W three cycles ahead of AW, partial strobes
    do_write(8'h08, 32'h1111_1111, 4'hF, resp);
    chk("t2_prior_resp", resp, 2'b00);
    WDATA = 32'hAABB_CCDD; WSTRB = 4'b0101; WVALID = 1; BREADY = 1;
    step();
    WVALID = 0;
    chk("t2_wready_held", WREADY, 0); chk("t2_awready_open", AWREADY, 1);
    step(); step();
    AWADDR = 8'h08; AWVALID = 1;
    step();
    AWVALID = 0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (BVALID) bcnt++;
    end
    chk("t2_word2", word(2), 32'h11BB_11DD); chk("t2_b_count", bcnt, 1);

    // ---- T3: write to RO status word, read unmapped, legal reads
    p0 = pulse_cnt;
    do_write(8'h20, 32'hDEAD_BEEF, 4'hF, resp);
    chk("t3_bresp_slverr", resp, 2'b10);
    chk("t3_no_pulse", pulse_cnt - p0, 0);
    chk("t3_regout_lo", reg_out[127:0], {32'h0, 32'h11BB_11DD, 32'h1234_5678, 32'h0});
    chk("t3_regout_hi", reg_out[255:128], 128'h0);
    do_read(8'hFC, rd, resp);
    chk("t3_err_rdata", rd, 32'hAAAA_5555); chk("t3_err_rresp", resp, 2'b10);
    do_read(8'h04, rd, resp);
    chk("t3_rd_word1", rd, 32'h1234_5678); chk("t3_rd_word1_resp", resp, 2'b00);
    sts_in[63:32] = 32'hCAFE_0001;
    step();
    do_read(8'h25, rd, resp);                 // low bits ignored -> status word1
    chk("t3_rd_sts1", rd, 32'hCAFE_0001); chk("t3_rd_sts1_resp", resp, 2'b00);

    // ---- T4: full backpressure on both channels
    AWADDR = 8'h0C; WDATA = 32'h55AA_55AA; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 8'h08; ARVALID = 1; BREADY = 0; RREADY = 0;
    step();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid", BVALID, 1);   chk("t4_bresp", BRESP, 2'b00);
      chk("t4_rvalid", RVALID, 1);   chk("t4_rdata", RDATA, 32'h11BB_11DD); chk("t4_rresp", RRESP, 2'b00);
      chk("t4_awready", AWREADY, 0); chk("t4_wready", WREADY, 0); chk("t4_arready", ARREADY, 0);
      step();
    end
    BREADY = 1; RREADY = 1;
    step();
    chk("t4_bvalid_done", BVALID, 0); chk("t4_rvalid_done", RVALID, 0);
    chk("t4_awready_back", AWREADY, 1); chk("t4_arready_back", ARREADY, 1);
    chk("t4_word3", word(3), 32'h55AA_55AA);

    // ---- T4b: read captured on the commit edge sees the old value
    AWADDR = 8'h04; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    step();                                   // AW/W handshake
    AWVALID = 0; WVALID = 0; ARADDR = 8'h04; ARVALID = 1;
    step();                                   // commit edge == AR handshake edge
    ARVALID = 0;
    chk("t4b_word1_new", word(1), 32'h0BAD_F00D);
    step();
    chk("t4b_rvalid", RVALID, 1); chk("t4b_rdata_old", RDATA, 32'h1234_5678);
    step(); step();

    // ---- T5: reset with responses pending
    BREADY = 0; RREADY = 0;
    AWADDR = 8'h10; WDATA = 32'h0000_0077; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 8'h04; ARVALID = 1;
    step();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    step(); step();
    chk("t5_bvalid_pend", BVALID, 1); chk("t5_rvalid_pend", RVALID, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_bvalid", BVALID, 0); chk("t5_rvalid", RVALID, 0);
    chk("t5_awready", AWREADY, 0); chk("t5_arready", ARREADY, 0);
    chk("t5_rdata", RDATA, 0); chk("t5_regout", reg_out, 256'h0);
    step();
    rst = 1'b0; BREADY = 1; RREADY = 1;
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (BVALID || RVALID) bcnt++;
    end
    chk("t5_no_stale_resp", bcnt, 0);
    do_write(8'h00, 32'hA5A5_A5A5, 4'hF, resp);
    chk("t5_post_bresp", resp, 2'b00); chk("t5_post_word0", word(0), 32'hA5A5_A5A5);
    do_read(8'h00, rd, resp);
    chk("t5_post_rdata", rd, 32'hA5A5_A5A5);

    // ---- T6: status word0 behaviour
`ifdef AXIL_REGFILE_STS_RDCLR_EN
    sts_in[31:0] = 32'h8;
    step();
    sts_in[31:0] = 32'h0;
    step();
    do_read(8'h20, rd, resp);
    chk("t6_sticky_first", rd, 32'h8);
    do_read(8'h20, rd, resp);
    chk("t6_sticky_cleared", rd, 32'h0);
    ARADDR = 8'h20; ARVALID = 1; RREADY = 1; sts_in[31:0] = 32'h8;
    step();                                   // read and set on the same edge
    ARVALID = 0; sts_in[31:0] = 32'h0;
    step();
    chk("t6_setwin_rdata", RDATA, 32'h0);
    step();
    do_read(8'h20, rd, resp);
    chk("t6_setwin_kept", rd, 32'h8);
`else
    sts_in[31:0] = 32'h8;
    do_read(8'h20, rd, resp);
    chk("t6_sts_live", rd, 32'h8);
    sts_in[31:0] = 32'h0;
    do_read(8'h20, rd, resp);
    chk("t6_sts_live_zero", rd, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
